pipe_adder: RTL and testbench
=============================

PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4, pipeline depth; WIDTH % STAGES == 0; 1 <= STAGES <= WIDTH.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand beat offered.
REQ-006 SHALL have port in_ready  output  1  operand beat accepted when in_valid && in_ready.
REQ-007 SHALL have ports a, b  input  WIDTH  operands (two's complement or unsigned).
REQ-008 SHALL have port ci  input  1  carry-in.
REQ-009 SHALL have port out_valid  output  1  result beat present.
REQ-010 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready.
REQ-011 SHALL have port s  output  WIDTH  sum.
REQ-012 SHALL have port co  output  1  carry-out of MSB.
REQ-013 SHALL have port ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB).

Function
REQ-014 SHALL split the add into STAGES slices of WIDTH/STAGES bits; stage k adds slice k with carry registered from stage k-1.
REQ-015 SHALL skew operand slices on input and deskew sum slices on output so s, co, ovf of one beat emerge together.
REQ-016 SHALL produce result exactly STAGES cycles after acceptance when out_ready held high.
REQ-017 SHALL sustain one beat per cycle with out_ready high.
REQ-018 SHALL use single global advance: adv = !out_valid || out_ready; in_ready = adv; all stage registers and valid bits load only when adv.
REQ-019 SHALL hold s, co, ovf, out_valid stable while out_valid && !out_ready.
REQ-020 SHALL insert a bubble (valid bit 0) into stage 0 when adv && !in_valid; bubbles collapse as they reach the output.
REQ-021 SHALL wrap modulo 2^WIDTH: s = (a + b + ci) mod 2^WIDTH, co = bit WIDTH of full sum.
REQ-022 SHALL preserve beat order; no beat dropped or duplicated under any in_valid/out_ready pattern.
REQ-023 SHALL allow simultaneous accept and deliver in the same cycle.

Reset
REQ-024 SHALL on rst_n low clear all stage valid bits, out_valid = 0, s = 0, co = 0, ovf = 0, asynchronously.
REQ-025 SHALL discard in-flight beats on reset mid-operation; in_ready = 1 in the first cycle after release.

Configuration
REQ-026 SHALL compile, when PIPE_ADDER_SUB_EN is defined, an extra port sub (input, 1) travelling with the beat; sub = 1 computes a + ~b + 1 (ci ignored), co = 1 meaning no borrow.
REQ-027 SHALL, when PIPE_ADDER_SUB_EN is undefined, have no sub port and perform addition only.

Structure
REQ-028 SHALL place slice-width constant derivation and status-flag bit positions in shared package pipe_adder_pkg.
REQ-029 SHALL instantiate one sub-module add_slice (combinational, parametrised slice width, ports a, b, ci, s, co, c_msb) per stage.

Verification (WIDTH=8, STAGES=2)
REQ-030 SHALL check: a=0x0F, b=0x01, ci=0, out_ready=1 -> after 2 cycles s=0x10, co=0, ovf=0.
REQ-031 SHALL check: a=0x7F, b=0x01 -> s=0x80, co=0, ovf=1; a=0xFF, b=0x01 -> s=0x00, co=1, ovf=0.
REQ-032 SHALL check: 4 back-to-back beats, out_ready low 3 cycles mid-stream -> in_ready low during stall, outputs held, all 4 results in order.
REQ-033 SHALL check: rst_n pulsed low with 2 beats in flight -> out_valid=0 immediately, no stale result after release.
REQ-034 SHALL check (PIPE_ADDER_SUB_EN): a=0x05, b=0x07, sub=1 -> s=0xFE, co=0; a=0x07, b=0x05 -> s=0x02, co=1.
REQ-035 SHALL check: 1000 random beats with random in_valid/out_ready vs. reference model, zero mismatches.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// Shared constants for the pipelined adder: slice sizing and status-flag bit positions.
package pipe_adder_pkg;

    localparam int unsigned FLAG_CO  = 0;
    localparam int unsigned FLAG_OVF = 1;
    localparam int unsigned FLAG_W   = 2;

    // Bits handled by one pipeline stage.
    function automatic int unsigned slice_width(input int unsigned width, input int unsigned stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipe_adder_add_slice.sv
// One combinational slice of the ripple-through-registers adder.
module add_slice #(
    parameter int unsigned SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          ci,
    output logic [SW-1:0] s,
    output logic          co,
    output logic          c_msb
);

    logic [SW:0] sum_w;

    assign sum_w = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, ci};
    assign s     = sum_w[SW-1:0];
    assign co    = sum_w[SW];
    // Carry into the slice MSB recovered from the MSB sum bit.
    assign c_msb = a[SW-1] ^ b[SW-1] ^ sum_w[SW-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder split into STAGES slices with valid/ready flow control and a single global advance.
// Optional subtract mode (port sub) is compiled in when PIPE_ADDER_SUB_EN is defined.
module pipe_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    import pipe_adder_pkg::*;

    localparam int unsigned SW = slice_width(WIDTH, STAGES);

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             ci_eff;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Subtraction folds into the first slice as a + ~b + 1.
`ifdef PIPE_ADDER_SUB_EN
    assign b_eff  = sub ? ~b : b;
    assign ci_eff = sub ? 1'b1 : ci;
`else
    assign b_eff  = b;
    assign ci_eff = ci;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int unsigned DONE_W = (k + 1) * SW;

        logic [SW-1:0]     sl_a;
        logic [SW-1:0]     sl_b;
        logic [SW-1:0]     sl_s;
        logic              sl_ci;
        logic              sl_co;
        logic              sl_cm;
        logic              v_src;
        logic [DONE_W-1:0] sum_d;
        logic [DONE_W-1:0] sum_q;
        logic              valid_q;

        if (k == 0) begin : g_body
            assign sl_a  = a[SW-1:0];
            assign sl_b  = b_eff[SW-1:0];
            assign sl_ci = ci_eff;
            assign v_src = in_valid;
            assign sum_d = sl_s;
        end else begin : g_body
            assign sl_a  = g_st[k-1].g_fwd.a_q[SW-1:0];
            assign sl_b  = g_st[k-1].g_fwd.b_q[SW-1:0];
            assign sl_ci = g_st[k-1].g_fwd.carry_q;
            assign v_src = g_st[k-1].valid_q;
            assign sum_d = {sl_s, g_st[k-1].sum_q};
        end

        add_slice #(.SW(SW)) u_slice (
            .a    (sl_a),
            .b    (sl_b),
            .ci   (sl_ci),
            .s    (sl_s),
            .co   (sl_co),
            .c_msb(sl_cm)
        );

        // Completed low sum slices and the beat's valid bit.
        always_ff @(posedge clk or negedge rst_n) begin : p_stage
            if (!rst_n) begin
                valid_q <= 1'b0;
                sum_q   <= '0;
            end else if (adv) begin
                valid_q <= v_src;
                sum_q   <= sum_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            localparam int unsigned REM_W = (STAGES - 1 - k) * SW;

            logic [REM_W-1:0] a_d;
            logic [REM_W-1:0] b_d;
            logic [REM_W-1:0] a_q;
            logic [REM_W-1:0] b_q;
            logic             carry_q;
            logic             cm_unused;

            assign cm_unused = sl_cm;

            // Operand slices not yet consumed travel down, lowest pending slice at bit 0.
            if (k == 0) begin : g_src
                assign a_d = a[WIDTH-1:SW];
                assign b_d = b_eff[WIDTH-1:SW];
            end else begin : g_src
                assign a_d = g_st[k-1].g_fwd.a_q[REM_W+SW-1:SW];
                assign b_d = g_st[k-1].g_fwd.b_q[REM_W+SW-1:SW];
            end

            always_ff @(posedge clk or negedge rst_n) begin : p_fwd
                if (!rst_n) begin
                    a_q     <= '0;
                    b_q     <= '0;
                    carry_q <= 1'b0;
                end else if (adv) begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    carry_q <= sl_co;
                end
            end
        end else begin : g_tail
            logic [FLAG_W-1:0] flag_q;

            always_ff @(posedge clk or negedge rst_n) begin : p_flag
                if (!rst_n) begin
                    flag_q <= '0;
                end else if (adv) begin
                    flag_q[FLAG_CO]  <= sl_co;
                    flag_q[FLAG_OVF] <= sl_cm ^ sl_co;
                end
            end
        end
    end

    assign out_valid = g_st[STAGES-1].valid_q;
    assign s         = g_st[STAGES-1].sum_q;
    assign co        = g_st[STAGES-1].g_tail.flag_q[FLAG_CO];
    assign ovf       = g_st[STAGES-1].g_tail.flag_q[FLAG_OVF];

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder at WIDTH=8, STAGES=2; subtract cases run when PIPE_ADDER_SUB_EN is defined.
module tb_pipe_adder;

    localparam int unsigned W  = 8;
    localparam int unsigned ST = 2;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ovf;
        int           cyc;
        bit           lat;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sub_v;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;

    exp_t         sbq[$];
    int           cyc;
    int           n_chk;
    int           n_bad;
    int           n_acc;
    logic         hold_pend;
    logic [W-1:0] hold_s;
    logic         hold_co;
    logic         hold_ovf;

    pipe_adder #(.WIDTH(W), .STAGES(ST)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .ci       (ci),
`ifdef PIPE_ADDER_SUB_EN
        .sub      (sub_v),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .co       (co),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference: plain 9-bit sum; overflow when same-sign operands give a different-sign result.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic sb, input bit lat);
        exp_t         e;
        logic [W-1:0] yy;
        logic         cc;
        logic [W:0]   f;
        yy    = sb ? ~y : y;
        cc    = sb ? 1'b1 : c;
        f     = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
        e.s   = f[W-1:0];
        e.co  = f[W];
        e.ovf = (x[W-1] == yy[W-1]) && (f[W-1] != x[W-1]);
        e.cyc = 0;
        e.lat = lat;
        return e;
    endfunction

    // Drive one cycle at the negedge, then score both handshakes for the coming rising edge.
    task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ici, input logic ordy, input exp_t e);
        exp_t h;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        ci        = ici;
        out_ready = ordy;
        #1;
        if (hold_pend) begin
            chk("hold_v", 32'(out_valid), 32'(1));
            chk("hold_s", 32'(s), 32'(hold_s));
            chk("hold_co", 32'(co), 32'(hold_co));
            chk("hold_ovf", 32'(ovf), 32'(hold_ovf));
        end
        if (out_valid && !out_ready) chk("stall_rdy", 32'(in_ready), 32'(0));
        else                         chk("go_rdy", 32'(in_ready), 32'(1));
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("stale", 32'(out_valid), 32'(0));
            end else begin
                h = sbq.pop_front();
                chk("s", 32'(s), 32'(h.s));
                chk("co", 32'(co), 32'(h.co));
                chk("ovf", 32'(ovf), 32'(h.ovf));
                if (h.lat) chk("lat", 32'(cyc - h.cyc), 32'(ST));
            end
        end
        if (in_valid && in_ready) begin
            h     = e;
            h.cyc = cyc;
            sbq.push_back(h);
            n_acc++;
        end
        hold_pend = out_valid && !out_ready;
        hold_s    = s;
        hold_co   = co;
        hold_ovf  = ovf;
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, '0, '0, 1'b0, ordy, model('0, '0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic beat(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ici,
                        input logic [W-1:0] es, input logic eco, input logic eovf);
        exp_t e;
        e.s   = es;
        e.co  = eco;
        e.ovf = eovf;
        e.cyc = 0;
        e.lat = 1'b1;
        step(1'b1, ia, ib, ici, 1'b1, e);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sbq.size() != 0; i++) idle(1'b1);
        idle(1'b1);
        chk("drain", 32'(sbq.size()), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [W-1:0] sa [4];
        logic [W-1:0] sbv [4];
        logic [W-1:0] xa;
        logic [W-1:0] xb;
        logic         xc;
        int           k;
        int           acc0;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        ci        = 1'b0;
        sub_v     = 1'b0;
        out_ready = 1'b0;
        cyc       = 0;
        n_chk     = 0;
        n_bad     = 0;
        n_acc     = 0;
        hold_pend = 1'b0;
        hold_s    = '0;
        hold_co   = 1'b0;
        hold_ovf  = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_ov", 32'(out_valid), 32'(0));
        chk("rst_s", 32'(s), 32'(0));
        chk("rst_co", 32'(co), 32'(0));
        chk("rst_ovf", 32'(ovf), 32'(0));
        rst_n = 1'b1;
        #1;
        chk("rel_rdy", 32'(in_ready), 32'(1));

        // Directed sums with hand-computed results, back to back.
        beat(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        beat(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        beat(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        beat(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1);
        beat(8'h3C, 8'hC3, 1'b1, 8'h00, 1'b1, 1'b0);
        beat(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
        drain();

`ifdef PIPE_ADDER_SUB_EN
        sub_v = 1'b1;
        beat(8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
        beat(8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0);
        beat(8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
        drain();
        sub_v = 1'b0;
`endif

        // Four beats offered back to back; output stalls for three cycles mid-stream.
        sa  = '{8'h12, 8'h9C, 8'h7F, 8'hF0};
        sbv = '{8'h34, 8'h9C, 8'h7F, 8'h20};
        k   = 0;
        for (int j = 0; j < 14; j++) begin
            acc0 = n_acc;
            step(k < 4, sa[k & 3], sbv[k & 3], 1'b0, !(j >= 2 && j < 5),
                 model(sa[k & 3], sbv[k & 3], 1'b0, 1'b0, 1'b0));
            if (n_acc != acc0) k++;
        end
        chk("stall_cnt", 32'(k), 32'(4));
        drain();

        // Reset with two beats in flight.
        step(1'b1, 8'h21, 8'h43, 1'b0, 1'b0, model(8'h21, 8'h43, 1'b0, 1'b0, 1'b0));
        step(1'b1, 8'h55, 8'h66, 1'b1, 1'b0, model(8'h55, 8'h66, 1'b1, 1'b0, 1'b0));
        idle(1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ov", 32'(out_valid), 32'(0));
        chk("mid_rst_s", 32'(s), 32'(0));
        chk("mid_rst_co", 32'(co), 32'(0));
        sbq.delete();
        hold_pend = 1'b0;
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        #1;
        chk("mid_rel_rdy", 32'(in_ready), 32'(1));
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            chk("post_rst_ov", 32'(out_valid), 32'(0));
        end

        // Random traffic against the reference model.
        acc0 = n_acc;
        for (int g = 0; g < 20000 && (n_acc - acc0) < 1000; g++) begin
            xa = W'($urandom);
            xb = W'($urandom);
            xc = 1'($urandom_range(0, 1));
`ifdef PIPE_ADDER_SUB_EN
            sub_v = 1'($urandom_range(0, 1));
`endif
            step($urandom_range(0, 3) != 0, xa, xb, xc, $urandom_range(0, 3) != 0,
                 model(xa, xb, xc, sub_v, 1'b0));
        end
        chk("rand_cnt", 32'(n_acc - acc0), 32'(1000));
        sub_v = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
